sched_ws: RTL and testbench

SCHED_WS -- requirements
Module: sched_ws

---
 rtl/sched_ws_if.sv | 29 ++
 rtl/sched_ws.sv | 138 +++++++++++++
 tb/tb_sched_ws.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/sched_ws_if.sv
// Scheduler control/status bundle: instruction attributes and bus ready in, phase strobes and status out.
// Slave modport is the scheduler side; master modport is the core/bench side.
interface sched_ws_if #(
   parameter int CNT_WIDTH = 32
);
   logic                 need_mem;
   logic                 need_wb;
   logic                 mem_ready;
   logic                 halt_req;
   logic                 step;
   logic                 phf;
   logic                 phe;
   logic                 phm;
   logic                 phw;
   logic                 halted;
   logic                 bus_err;
   logic [CNT_WIDTH-1:0] inst_cnt;
   logic [2:0]           clk_stat;

   modport master (
      output need_mem, need_wb, mem_ready, halt_req, step,
      input  phf, phe, phm, phw, halted, bus_err, inst_cnt, clk_stat
   );

   modport slave (
      input  need_mem, need_wb, mem_ready, halt_req, step,
      output phf, phe, phm, phw, halted, bus_err, inst_cnt, clk_stat
   );
endinterface

// File: rtl/sched_ws.sv
// Instruction phase scheduler (F/E/M/W + halt), one state per cycle; F and M stall on mem_ready=0
// and a stall reaching TIMEOUT parks the scheduler in H with a sticky bus error.
module sched_ws #(
   parameter int CNT_WIDTH = 32,
   parameter int TIMEOUT   = 255,
   parameter int TW        = 8
) (
   input  logic        clk,
   input  logic        reset,
   sched_ws_if.slave   bus
);

   typedef enum logic [2:0] {
      ST_H = 3'd0,
      ST_F = 3'd1,
      ST_E = 3'd2,
      ST_M = 3'd3,
      ST_W = 3'd4
   } state_t;

   localparam logic [TW-1:0] WCNT_MAX  = '1;
   localparam logic [TW-1:0] WCNT_LAST = TW'(TIMEOUT - 1);

   state_t               state_q, state_d;
   logic [3:0]           ph_q, ph_d;
   logic                 bus_err_q, bus_err_d;
   logic                 step_pend_q, step_pend_d;
   logic                 step_q, step_d;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
   logic [TW-1:0]        wcnt_q, wcnt_d;

   logic step_rise;
   logic waiting;
   logic timeout_hit;
   logic inst_end;

   assign step_rise   = bus.step & ~step_q;
   assign waiting     = ((state_q == ST_F) || (state_q == ST_M)) && !bus.mem_ready;
   assign timeout_hit = (TIMEOUT != 0) && waiting && (wcnt_q >= WCNT_LAST);

   always_comb begin
      state_d     = state_q;
      bus_err_d   = bus_err_q;
      step_pend_d = step_pend_q;
      cnt_d       = cnt_q;
      step_d      = bus.step;
      wcnt_d      = wcnt_q;
      ph_d        = 4'b0000;
      inst_end    = 1'b0;

      case (state_q)
         ST_F: begin
            if (timeout_hit) begin
               state_d   = ST_H;
               bus_err_d = 1'b1;
            end else if (bus.mem_ready) begin
               state_d = ST_E;
            end
         end
         ST_E: begin
            if (bus.need_mem)      state_d  = ST_M;
            else if (bus.need_wb)  state_d  = ST_W;
            else                   inst_end = 1'b1;
         end
         ST_M: begin
            if (timeout_hit) begin
               state_d   = ST_H;
               bus_err_d = 1'b1;
            end else if (bus.mem_ready) begin
               if (bus.need_wb) state_d  = ST_W;
               else             inst_end = 1'b1;
            end
         end
         ST_W: inst_end = 1'b1;
         ST_H: begin
            // A latched bus error pins the scheduler here until reset.
            if (!bus_err_q) begin
               if (step_rise) begin
                  state_d     = ST_F;
                  step_pend_d = 1'b1;
               end else if (!bus.halt_req) begin
                  state_d     = ST_F;
                  step_pend_d = 1'b0;
               end
            end
         end
         default: state_d = ST_F;
      endcase

      if (inst_end) begin
         cnt_d   = cnt_q + 1'b1;
         state_d = (bus.halt_req || step_pend_q) ? ST_H : ST_F;
      end

      if ((state_d == ST_H) && (state_q != ST_H)) step_pend_d = 1'b0;

      if (state_d != state_q)               wcnt_d = '0;
      else if (waiting && wcnt_q != WCNT_MAX) wcnt_d = wcnt_q + 1'b1;

      case (state_d)
         ST_F:    ph_d = 4'b0001;
         ST_E:    ph_d = 4'b0010;
         ST_M:    ph_d = 4'b0100;
         ST_W:    ph_d = 4'b1000;
         default: ph_d = 4'b0000;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_F;
         ph_q        <= 4'b0001;
         bus_err_q   <= 1'b0;
         step_pend_q <= 1'b0;
         step_q      <= 1'b0;
         cnt_q       <= '0;
         wcnt_q      <= '0;
      end else begin
         state_q     <= state_d;
         ph_q        <= ph_d;
         bus_err_q   <= bus_err_d;
         step_pend_q <= step_pend_d;
         step_q      <= step_d;
         cnt_q       <= cnt_d;
         wcnt_q      <= wcnt_d;
      end
   end

   assign bus.phf      = ph_q[0];
   assign bus.phe      = ph_q[1];
   assign bus.phm      = ph_q[2];
   assign bus.phw      = ph_q[3];
   assign bus.halted   = (state_q == ST_H);
   assign bus.bus_err  = bus_err_q;
   assign bus.inst_cnt = cnt_q;
   assign bus.clk_stat = (state_q == ST_H) ? {3{bus_err_q}} : state_q;

endmodule

// File: tb/tb_sched_ws.sv
// Bench for sched_ws: per-cycle expected state codes are queued as stimulus is driven and
// compared on the falling edge; counters and reset behaviour are checked directly.
module tb_sched_ws;

   logic clk;
   logic reset;
   int   n_chk;
   int   n_err;

   logic [2:0] exp_q[$];

   sched_ws_if #(.CNT_WIDTH(4)) bus ();

   sched_ws #(
      .CNT_WIDTH (4),
      .TIMEOUT   (4),
      .TW        (8)
   ) u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [3:0] ph_of(input logic [2:0] s);
      case (s)
         3'd1:    return 4'b0001;
         3'd2:    return 4'b0010;
         3'd3:    return 4'b0100;
         3'd4:    return 4'b1000;
         default: return 4'b0000;
      endcase
   endfunction

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         logic [2:0] e;
         e = exp_q.pop_front();
         chk("clk_stat", {29'd0, bus.clk_stat}, {29'd0, e});
         chk("phases", {28'd0, bus.phw, bus.phm, bus.phe, bus.phf}, {28'd0, ph_of(e)});
         chk("halted", {31'd0, bus.halted}, {31'd0, (e == 3'd0) || (e == 3'd7)});
      end
   end

   // in = {need_mem, need_wb, mem_ready, halt_req, step}; exp = state shown while these inputs are applied.
   task automatic cyc(input logic [4:0] in, input logic [2:0] exp);
      exp_q.push_back(exp);
      {bus.need_mem, bus.need_wb, bus.mem_ready, bus.halt_req, bus.step} = in;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_stat"},  {29'd0, bus.clk_stat}, 32'd1);
      chk({tag, "_ph"},    {28'd0, bus.phw, bus.phm, bus.phe, bus.phf}, 32'b0001);
      chk({tag, "_halt"},  {31'd0, bus.halted}, 32'd0);
      chk({tag, "_err"},   {31'd0, bus.bus_err}, 32'd0);
      chk({tag, "_cnt"},   {28'd0, bus.inst_cnt}, 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      n_chk = 0;
      n_err = 0;
      {bus.need_mem, bus.need_wb, bus.mem_ready, bus.halt_req, bus.step} = 5'b0;
      reset = 1'b1;
      #1 reset = 1'b0;
      #1 chk_reset_vals("rst0");
      @(posedge clk);
      #1 reset = 1'b1;

      // Three F,E,W instructions back to back.
      for (int i = 0; i < 3; i++) begin
         cyc(5'b01100, 3'd1);
         cyc(5'b01100, 3'd2);
         cyc(5'b01100, 3'd4);
      end
      chk("cnt_few", {28'd0, bus.inst_cnt}, 32'd3);

      // F stalls 2, M stalls 3; ready arrives on the cycle the wait count would time out.
      cyc(5'b11000, 3'd1);
      cyc(5'b11000, 3'd1);
      cyc(5'b11100, 3'd1);
      cyc(5'b11000, 3'd2);
      cyc(5'b11000, 3'd3);
      cyc(5'b11000, 3'd3);
      cyc(5'b11000, 3'd3);
      cyc(5'b11100, 3'd3);
      cyc(5'b11100, 3'd4);
      chk("cnt_wait", {28'd0, bus.inst_cnt}, 32'd4);
      chk("err_wait", {31'd0, bus.bus_err}, 32'd0);

      // Halt mid-instruction, two single steps, then release.
      cyc(5'b01100, 3'd1);
      cyc(5'b01110, 3'd2);
      cyc(5'b01110, 3'd4);
      cyc(5'b01110, 3'd0);
      chk("cnt_halt", {28'd0, bus.inst_cnt}, 32'd5);
      cyc(5'b01111, 3'd0);
      cyc(5'b01110, 3'd1);
      cyc(5'b01110, 3'd2);
      cyc(5'b01110, 3'd4);
      chk("cnt_step1", {28'd0, bus.inst_cnt}, 32'd6);
      cyc(5'b01111, 3'd0);
      cyc(5'b01110, 3'd1);
      cyc(5'b01110, 3'd2);
      cyc(5'b01110, 3'd4);
      chk("cnt_step2", {28'd0, bus.inst_cnt}, 32'd7);
      cyc(5'b01100, 3'd0);
      cyc(5'b01100, 3'd1);
      cyc(5'b01100, 3'd2);
      cyc(5'b01100, 3'd4);
      chk("cnt_resume", {28'd0, bus.inst_cnt}, 32'd8);

      // Nine minimum-length instructions wrap the 4-bit count to 1; a step edge in F is ignored.
      for (int i = 0; i < 9; i++) begin
         cyc((i == 0) ? 5'b00101 : 5'b00100, 3'd1);
         cyc(5'b00100, 3'd2);
      end
      chk("cnt_wrap", {28'd0, bus.inst_cnt}, 32'd1);

      // Timeout in M: four wait cycles, then H with bus error; step and halt release ignored.
      cyc(5'b10100, 3'd1);
      cyc(5'b10000, 3'd2);
      for (int i = 0; i < 4; i++) cyc(5'b10000, 3'd3);
      cyc(5'b10001, 3'd7);
      cyc(5'b10000, 3'd7);
      cyc(5'b10001, 3'd7);
      cyc(5'b00100, 3'd7);
      chk("err_set", {31'd0, bus.bus_err}, 32'd1);
      chk("cnt_err", {28'd0, bus.inst_cnt}, 32'd1);

      #2 reset = 1'b0;
      #1 chk_reset_vals("rst_err");
      @(posedge clk);
      #1 reset = 1'b1;

      // Reset during an M stall takes effect before the next edge.
      cyc(5'b10100, 3'd1);
      cyc(5'b10000, 3'd2);
      cyc(5'b10000, 3'd3);
      cyc(5'b10000, 3'd3);
      #2 reset = 1'b0;
      #1 chk_reset_vals("rst_m");
      @(posedge clk);
      #1 reset = 1'b1;

      // First edge after release evaluates F with mem_ready.
      cyc(5'b00000, 3'd1);
      cyc(5'b00100, 3'd1);
      cyc(5'b00100, 3'd2);
      cyc(5'b00100, 3'd1);
      chk("cnt_post", {28'd0, bus.inst_cnt}, 32'd1);
      chk("sb_drain", exp_q.size(), 32'd0);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
